// File: rtl/miriscv_lsu.sv
// Load-store unit: drives a req/gnt/rvalid data-memory port and stalls the core until done.
// Optional macro LSU_MISALIGN_EN adds misaligned-access detection (lsu_misaligned_o).
module miriscv_lsu #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [2:0]        lsu_size_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [DATA_W-1:0] lsu_data_i,
  output logic [DATA_W-1:0] lsu_data_o,
  output logic              lsu_stall_req_o,
  output logic              data_req_o,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [DATA_W-1:0] data_wdata_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  input  logic [DATA_W-1:0] data_rdata_i
`ifdef LSU_MISALIGN_EN
  ,
  output logic              lsu_misaligned_o
`endif
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] WAIT_RV = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              we_q;
  logic [2:0]        size_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_ext;
  logic [7:0]        rbyte;
  logic [15:0]       rhalf;
  logic              misaligned;
`ifdef LSU_MISALIGN_EN
  logic              misaligned_q;
`endif

  // Byte enables and lane-replicated store data from the live request.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = lsu_data_i;
    case (lsu_size_i[1:0])
      2'd0: begin
        be_d    = 4'b0001 << lsu_addr_i[1:0];
        wdata_d = {4{lsu_data_i[7:0]}};
      end
      2'd1: begin
        be_d    = 4'b0011 << {lsu_addr_i[1], 1'b0};
        wdata_d = {2{lsu_data_i[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = lsu_data_i;
      end
    endcase
  end

`ifdef LSU_MISALIGN_EN
  always_comb begin
    misaligned = 1'b0;
    case (lsu_size_i[1:0])
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = lsu_addr_i[0];
      default: misaligned = (lsu_addr_i[1:0] != 2'b00);
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  // Load extraction uses the offset/size latched at request time.
  always_comb begin
    case (off_q)
      2'd0:    rbyte = data_rdata_i[7:0];
      2'd1:    rbyte = data_rdata_i[15:8];
      2'd2:    rbyte = data_rdata_i[23:16];
      default: rbyte = data_rdata_i[31:24];
    endcase
    rhalf = off_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    case (size_q[1:0])
      2'd0:    rdata_ext = size_q[2] ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
      2'd1:    rdata_ext = size_q[2] ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
      default: rdata_ext = data_rdata_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (lsu_req_i) state_d = misaligned ? DONE : REQ;
      end
      REQ: begin
        if (data_gnt_i) state_d = we_q ? DONE : WAIT_RV;
      end
      WAIT_RV: begin
        if (data_rvalid_i) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 3'd0;
      off_q   <= 2'd0;
      addr_q  <= '0;
      be_q    <= 4'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && lsu_req_i) begin
        we_q    <= lsu_we_i;
        size_q  <= lsu_size_i;
        off_q   <= lsu_addr_i[1:0];
        addr_q  <= lsu_addr_i;
        be_q    <= be_d;
        wdata_q <= wdata_d;
      end
      if (state_q == WAIT_RV && data_rvalid_i) rdata_q <= rdata_ext;
    end
  end

`ifdef LSU_MISALIGN_EN
  // Set only on the IDLE -> DONE shortcut, so it is high for that DONE cycle alone.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) misaligned_q <= 1'b0;
    else         misaligned_q <= (state_q == IDLE) && lsu_req_i && misaligned;
  end
  assign lsu_misaligned_o = misaligned_q && (state_q == DONE);
`endif

  always_comb begin
    case (state_q)
      IDLE:    lsu_stall_req_o = lsu_req_i;
      REQ:     lsu_stall_req_o = 1'b1;
      WAIT_RV: lsu_stall_req_o = 1'b1;
      default: lsu_stall_req_o = 1'b0;
    endcase
  end

  assign data_req_o   = (state_q == REQ);
  assign data_we_o    = we_q;
  assign data_be_o    = be_q;
  assign data_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
  assign data_wdata_o = wdata_q;
  assign lsu_data_o   = rdata_q;

endmodule

// File: tb/tb_miriscv_lsu.sv
// Directed self-checking bench for miriscv_lsu; covers the misaligned option when
// LSU_MISALIGN_EN is defined.
module tb_miriscv_lsu;

  logic        clk;
  logic        rstn;
  logic        lsu_req;
  logic        lsu_we;
  logic [2:0]  lsu_size;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [31:0] lsu_data;
  logic        stall;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
`ifdef LSU_MISALIGN_EN
  logic        misaligned;
`endif

  int checks = 0;
  int errors = 0;

  miriscv_lsu #(
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .lsu_req_i      (lsu_req),
    .lsu_we_i       (lsu_we),
    .lsu_size_i     (lsu_size),
    .lsu_addr_i     (lsu_addr),
    .lsu_data_i     (lsu_wdata),
    .lsu_data_o     (lsu_data),
    .lsu_stall_req_o(stall),
    .data_req_o     (data_req),
    .data_we_o      (data_we),
    .data_be_o      (data_be),
    .data_addr_o    (data_addr),
    .data_wdata_o   (data_wdata),
    .data_gnt_i     (data_gnt),
    .data_rvalid_i  (data_rvalid),
    .data_rdata_i   (data_rdata)
`ifdef LSU_MISALIGN_EN
    ,
    .lsu_misaligned_o(misaligned)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // One full access. Inputs change after the IDLE cycle to prove the request was latched;
  // rvalid pulses with junk data while waiting for gnt and must be ignored.
  // lsu_req stays high in DONE, where it must be ignored.
  task automatic access(input string tag, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int gnt_wait, input int rv_wait, input logic [31:0] rdata,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_data);
    lsu_req   = 1'b1;
    lsu_we    = we;
    lsu_size  = size;
    lsu_addr  = addr;
    lsu_wdata = wdata;
    #3;
    chk({tag, "_idle_stall"}, 32'(stall), 32'd1);
    chk({tag, "_idle_req"}, 32'(data_req), 32'd0);
    next();
    lsu_addr  = 32'hFFFF_FFFF;
    lsu_wdata = 32'h0;
    lsu_size  = 3'd2;
    for (int i = 0; i <= gnt_wait; i++) begin
      data_gnt    = (i == gnt_wait);
      data_rvalid = (i != gnt_wait);
      data_rdata  = 32'h5555_5555;
      #3;
      chk({tag, "_req"}, 32'(data_req), 32'd1);
      chk({tag, "_req_stall"}, 32'(stall), 32'd1);
      chk({tag, "_we"}, 32'(data_we), 32'(we));
      chk({tag, "_be"}, 32'(data_be), 32'(exp_be));
      chk({tag, "_addr"}, data_addr, {addr[31:2], 2'b00});
      if (we) chk({tag, "_wdata"}, data_wdata, exp_wdata);
      next();
    end
    data_gnt    = 1'b0;
    data_rvalid = 1'b0;
    if (!we) begin
      for (int i = 0; i <= rv_wait; i++) begin
        data_rvalid = (i == rv_wait);
        data_rdata  = (i == rv_wait) ? rdata : 32'h0;
        #3;
        chk({tag, "_wait_req"}, 32'(data_req), 32'd0);
        chk({tag, "_wait_stall"}, 32'(stall), 32'd1);
        next();
      end
      data_rvalid = 1'b0;
    end
    #3;
    chk({tag, "_done_stall"}, 32'(stall), 32'd0);
    chk({tag, "_done_req"}, 32'(data_req), 32'd0);
    chk({tag, "_data"}, lsu_data, exp_data);
    next();
  endtask

  initial begin
    rstn        = 1'b0;
    lsu_req     = 1'b0;
    lsu_we      = 1'b0;
    lsu_size    = 3'd0;
    lsu_addr    = 32'h0;
    lsu_wdata   = 32'h0;
    data_gnt    = 1'b0;
    data_rvalid = 1'b0;
    data_rdata  = 32'h0;
    next();
    next();
    #3;
    chk("rst_data", lsu_data, 32'h0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(data_req), 32'd0);
    chk("rst_be", 32'(data_be), 32'd0);
    chk("rst_addr", data_addr, 32'h0);
    chk("rst_wdata", data_wdata, 32'h0);
    rstn = 1'b1;
    next();
    #3;
    chk("idle_no_req_stall", 32'(stall), 32'd0);
    next();

    // LB, offset 3: byte 0x80 sign-extended
    access("lb", 1'b0, 3'd0, 32'h0000_1003, 32'h0, 0, 0, 32'h80FF_0000,
           4'b1000, 32'h0, 32'hFFFF_FF80);
    lsu_req = 1'b0;
    #3;
    chk("lb_hold", lsu_data, 32'hFFFF_FF80);
    chk("lb_idle_stall", 32'(stall), 32'd0);
    next();

    // LHU then LH on the upper halfword, with slow gnt and rvalid
    access("lhu", 1'b0, 3'd5, 32'h0000_2002, 32'h0, 2, 1, 32'hBEEF_1234,
           4'b1100, 32'h0, 32'h0000_BEEF);
    access("lh", 1'b0, 3'd1, 32'h0000_2002, 32'h0, 0, 2, 32'hBEEF_1234,
           4'b1100, 32'h0, 32'hFFFF_BEEF);
    // LBU offset 1: zero-extended
    access("lbu", 1'b0, 3'd4, 32'h0000_2101, 32'h0, 0, 0, 32'h0000_F200,
           4'b0010, 32'h0, 32'h0000_00F2);

    // SB with gnt delayed 3 cycles; lsu_data_o must not change on a store
    access("sb", 1'b1, 3'd0, 32'h0000_3001, 32'h1234_56AB, 3, 0, 32'h0,
           4'b0010, 32'hABAB_ABAB, 32'h0000_00F2);
    access("sh", 1'b1, 3'd1, 32'h0000_3002, 32'h0000_CAFE, 0, 0, 32'h0,
           4'b1100, 32'hCAFE_CAFE, 32'h0000_00F2);

    // SW then back-to-back LW to the same word
    access("sw", 1'b1, 3'd2, 32'h0000_4000, 32'h0102_0304, 0, 0, 32'h0,
           4'b1111, 32'h0102_0304, 32'h0000_00F2);
    access("lw", 1'b0, 3'd2, 32'h0000_4000, 32'h0, 0, 0, 32'hDEAD_BEEF,
           4'b1111, 32'h0, 32'hDEAD_BEEF);
    // Size 3 behaves as a word
    access("sz3", 1'b0, 3'd3, 32'h0000_7000, 32'h0, 0, 0, 32'h0000_8001,
           4'b1111, 32'h0, 32'h0000_8001);

`ifdef LSU_MISALIGN_EN
    // LW at offset 2: no memory transaction, one-cycle misaligned flag
    lsu_req  = 1'b1;
    lsu_we   = 1'b0;
    lsu_size = 3'd2;
    lsu_addr = 32'h0000_5002;
    #3;
    chk("mis_idle_stall", 32'(stall), 32'd1);
    chk("mis_idle_flag", 32'(misaligned), 32'd0);
    next();
    lsu_req = 1'b0;
    #3;
    chk("mis_done_flag", 32'(misaligned), 32'd1);
    chk("mis_done_stall", 32'(stall), 32'd0);
    chk("mis_done_req", 32'(data_req), 32'd0);
    chk("mis_data", lsu_data, 32'h0000_8001);
    next();
    #3;
    chk("mis_after_flag", 32'(misaligned), 32'd0);
    chk("mis_after_req", 32'(data_req), 32'd0);
    next();
`else
    // LH at offset 3 silently uses the upper halfword
    access("lh_off3", 1'b0, 3'd1, 32'h0000_2003, 32'h0, 0, 0, 32'hBEEF_1234,
           4'b1100, 32'h0, 32'hFFFF_BEEF);
`endif

    // Reset while in WAIT_RV; a following rvalid must be ignored
    lsu_req  = 1'b1;
    lsu_we   = 1'b0;
    lsu_size = 3'd2;
    lsu_addr = 32'h0000_6000;
    next();
    data_gnt = 1'b1;
    next();
    data_gnt = 1'b0;
    lsu_req  = 1'b0;
    #3;
    chk("rstmid_wait_stall", 32'(stall), 32'd1);
    rstn = 1'b0;
    next();
    rstn        = 1'b1;
    data_rvalid = 1'b1;
    data_rdata  = 32'h1234_5678;
    #3;
    chk("rstmid_data", lsu_data, 32'h0);
    chk("rstmid_stall", 32'(stall), 32'd0);
    chk("rstmid_req", 32'(data_req), 32'd0);
    chk("rstmid_be", 32'(data_be), 32'd0);
    next();
    data_rvalid = 1'b0;
    #3;
    chk("rstmid_rv_ignored", lsu_data, 32'h0);
    chk("rstmid_idle_stall", 32'(stall), 32'd0);
    next();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

endmodule
